// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared OARAM field layout and reader types
package ppu_pkg;

  // OARAM data word layout: activation in the low byte, channel-last flag on top.
  localparam int ACT_LSB           = 0;
  localparam int ACT_MSB           = 7;
  localparam int LAST_BIT          = 24;
  localparam int OARAM_WORD_WIDTH  = 25;
  localparam int DEFAULT_TILE_SIZE = 256;

  typedef logic [OARAM_WORD_WIDTH-1:0]          oaram_word_t;
  typedef logic [7:0]                           activation_t;
  typedef logic [$clog2(DEFAULT_TILE_SIZE)-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } rd_state_t;

endpackage

// File: rtl/act_fifo2.sv
// rtl/act_fifo2.sv - two-entry first-word-fall-through FIFO for decoded activations
module act_fifo2
  import ppu_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  activation_t   push_value,
  input  logic [CW-1:0] push_row,
  input  logic [CW-1:0] push_column,
  input  logic          push_last,
  input  logic          pop,
  output logic          head_valid,
  output activation_t   head_value,
  output logic [CW-1:0] head_row,
  output logic [CW-1:0] head_column,
  output logic          head_last,
  output logic [1:0]    count
);

  typedef struct packed {
    activation_t   value;
    logic [CW-1:0] row;
    logic [CW-1:0] column;
    logic          last;
  } entry_t;

  entry_t mem [2];
  entry_t head;
  logic   wr_ptr;
  logic   rd_ptr;
  logic   do_push;
  logic   do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && (count != 2'd2);

  assign head        = mem[rd_ptr];
  assign head_valid  = (count != 2'd0);
  assign head_value  = head.value;
  assign head_row    = head.row;
  assign head_column = head.column;
  assign head_last   = head.last;

  // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= '{value: push_value, row: push_row, column: push_column, last: push_last};
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/oaram_reader.sv
// rtl/oaram_reader.sv - walks a compressed OARAM channel and streams decoded activations
module oaram_reader
  import ppu_pkg::*;
#(
  parameter int RAM_WIDTH   = 10,
  parameter int INDEX_WIDTH = 4,
  parameter int TILE_SIZE   = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [RAM_WIDTH-1:1]           base_address,
  output logic [RAM_WIDTH-1:1]           oaram_address,
  output logic                           oaram_read_enable,
  input  logic [24:0]                    oaram_value,
  input  logic [INDEX_WIDTH-1:0]         oaram_indices_value,
  output logic                           act_valid,
  input  logic                           act_ready,
  output logic [7:0]                     act_value,
  output logic [$clog2(TILE_SIZE)-1:0]   act_row,
  output logic [$clog2(TILE_SIZE)-1:0]   act_column,
  output logic                           act_last,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int            CW       = $clog2(TILE_SIZE);
  localparam int            AW       = RAM_WIDTH - 1;
  localparam logic [CW:0]   TILE_EXT = TILE_SIZE[CW:0];
  localparam logic [CW-1:0] ROW_MAX  = CW'(TILE_SIZE - 1);

  rd_state_t             state;
  rd_state_t             state_next;
  logic [RAM_WIDTH-1:1]  rd_addr;
  logic                  inflight;
  logic [CW-1:0]         row;
  logic [CW-1:0]         col;
  logic                  first_entry;
  logic                  overflow_q;

  activation_t           ret_act;
  logic                  ret_last;
  logic                  ret_push;
  logic                  last_returning;
  logic [CW:0]           col_sum;
  logic [CW:0]           col_wrapped;
  logic                  col_wrap;
  logic [CW-1:0]         col_dec;
  logic [CW-1:0]         row_dec;
  logic                  ovf_set;

  logic                  pop;
  logic [1:0]            fifo_count;
  logic [2:0]            occupancy;
  logic                  read_en;
  logic [15:0]           unused_oaram_bits;

  assign ret_act           = oaram_value[ACT_MSB:ACT_LSB];
  assign ret_last          = oaram_value[LAST_BIT];
  assign unused_oaram_bits = oaram_value[23:8];
  assign ret_push          = inflight && (ret_act != 8'd0);
  assign last_returning    = inflight && ret_last;

  assign pop = act_valid && act_ready;

  // Read credit: FIFO entries plus the word returning now, minus the entry leaving now, must
  // leave room for one more; counting the pop keeps one read per cycle under continuous ready.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign read_en   = (state == ST_FETCH) && !last_returning && (occupancy < 3'd2);

  assign oaram_read_enable = read_en;
  assign oaram_address     = rd_addr;
  assign busy              = (state != ST_IDLE);
  assign done              = (state == ST_DRAIN) && (fifo_count == 2'd0);
  assign overflow          = overflow_q;

  // Run-length decode of the returning word. first_entry is set when no emitted activation
  // occupies the current column (channel start or after filler), so no +1 step is taken then.
  always_comb begin
    col_sum     = {1'b0, col}
                + {{(CW + 1 - INDEX_WIDTH){1'b0}}, oaram_indices_value}
                + {{CW{1'b0}}, ~first_entry};
    col_wrapped = col_sum - TILE_EXT;
    col_wrap    = (col_sum >= TILE_EXT);
    col_dec     = col_wrap ? col_wrapped[CW-1:0] : col_sum[CW-1:0];
    row_dec     = row;
    ovf_set     = 1'b0;
    if (col_wrap) begin
      if (row == ROW_MAX) begin
        row_dec = '0;
        ovf_set = 1'b1;
      end else begin
        row_dec = row + CW'(1);
      end
    end
  end

  // Channel sequencing: fetch until the last-marked word returns, then drain the FIFO.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_FETCH;
      ST_FETCH: if (last_returning) state_next = ST_DRAIN;
      ST_DRAIN: if (fifo_count == 2'd0) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Read address, in-flight tracking and decoded position.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr     <= '0;
      inflight    <= 1'b0;
      row         <= '0;
      col         <= '0;
      first_entry <= 1'b1;
      overflow_q  <= 1'b0;
    end else begin
      inflight <= read_en;
      if (read_en) begin
        rd_addr <= rd_addr + AW'(1);
      end
      if ((state == ST_IDLE) && start) begin
        rd_addr     <= base_address;
        row         <= '0;
        col         <= '0;
        first_entry <= 1'b1;
        overflow_q  <= 1'b0;
      end
      if (inflight) begin
        col         <= col_dec;
        row         <= row_dec;
        first_entry <= (ret_act == 8'd0);
        if (ovf_set) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  act_fifo2 #(
    .CW(CW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (ret_push),
    .push_value  (ret_act),
    .push_row    (row_dec),
    .push_column (col_dec),
    .push_last   (ret_last),
    .pop         (pop),
    .head_valid  (act_valid),
    .head_value  (act_value),
    .head_row    (act_row),
    .head_column (act_column),
    .head_last   (act_last),
    .count       (fifo_count)
  );

endmodule
